// File: rtl/lsu_exec_unit.sv
// lsu_exec_unit: single-outstanding load/store unit with misalignment detection
module lsu_exec_unit (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [3:0]  lsu_uop_in,
   input  logic [31:0] base_in,
   input  logic [31:0] imm_in,
   input  logic [31:0] store_data_in,
   input  logic [4:0]  rd_in,
   output logic        lsu_busy_out,
   output logic        misaligned_out,
   output logic        mem_req_out,
   output logic        mem_we_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_wdata_out,
   output logic [3:0]  mem_wstrb_out,
   input  logic        mem_gnt_in,
   input  logic        mem_rvalid_in,
   input  logic [31:0] mem_rdata_in,
   output logic        wb_valid_out,
   output logic [4:0]  wb_rd_out,
   output logic [31:0] wb_data_out
);
   localparam logic [3:0] LB = 4'h1, LH = 4'h2, LW = 4'h3, LBU = 4'h4, LHU = 4'h5;
   localparam logic [3:0] SB = 4'h8, SH = 4'h9, SW = 4'hA;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;
   state_t      state_q, state_d;
   logic [3:0]  uop_q, uop_d, wstrb_q, wstrb_d;
   logic [1:0]  lo_q, lo_d;
   logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
   logic        we_q, we_d, mis_q, mis_d, wb_valid_q, wb_valid_d;
   logic [31:0] ea, ld_val;
   logic        legal, misal;
   logic [7:0]  lb;
   logic [15:0] lh;
   always_comb begin
      ea = base_in + imm_in;
      legal = lsu_uop_in inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
      misal = (lsu_uop_in inside {LH, LHU, SH} && ea[0]) || (lsu_uop_in inside {LW, SW} && ea[1:0] != 2'b00);
      lb = 8'(mem_rdata_in >> {lo_q, 3'b000});
      lh = 16'(mem_rdata_in >> {lo_q[1], 4'b0000});
      ld_val = uop_q == LB  ? {{24{lb[7]}}, lb} :
               uop_q == LBU ? {24'b0, lb} :
               uop_q == LH  ? {{16{lh[15]}}, lh} :
               uop_q == LHU ? {16'b0, lh} : mem_rdata_in;
      state_d = state_q;
      uop_d = uop_q;
      lo_d = lo_q;
      rd_d = rd_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      we_d = we_q;
      mis_d = 1'b0;
      wb_valid_d = 1'b0;
      wb_rd_d = wb_rd_q;
      wb_data_d = wb_data_q;
      case (state_q)
         IDLE: begin
            if (legal && misal) mis_d = 1'b1;
            else if (legal) begin
               state_d = REQ;
               uop_d = lsu_uop_in;
               lo_d = ea[1:0];
               rd_d = rd_in;
               addr_d = {ea[31:2], 2'b00};
               we_d = lsu_uop_in[3];
               wdata_d = lsu_uop_in == SB ? {4{store_data_in[7:0]}} :
                         lsu_uop_in == SH ? {2{store_data_in[15:0]}} : store_data_in;
               wstrb_d = lsu_uop_in == SB ? 4'b0001 << ea[1:0] :
                         lsu_uop_in == SH ? (ea[1] ? 4'b1100 : 4'b0011) :
                         lsu_uop_in == SW ? 4'b1111 : 4'b0000;
            end
         end
         REQ: if (mem_gnt_in) state_d = we_q ? IDLE : WAIT;
         WAIT: if (mem_rvalid_in) begin
            state_d = WB;
            // rd=0 loads leave the writeback outputs untouched
            wb_valid_d = rd_q != 5'd0;
            wb_rd_d = rd_q != 5'd0 ? rd_q : wb_rd_q;
            wb_data_d = rd_q != 5'd0 ? ld_val : wb_data_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         uop_q <= '0;
         lo_q <= '0;
         rd_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         we_q <= 1'b0;
         mis_q <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q <= '0;
         wb_data_q <= '0;
      end else begin
         state_q <= state_d;
         uop_q <= uop_d;
         lo_q <= lo_d;
         rd_q <= rd_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         we_q <= we_d;
         mis_q <= mis_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end
   assign lsu_busy_out = state_q != IDLE;
   assign mem_req_out = state_q == REQ;
   assign misaligned_out = mis_q;
   assign mem_we_out = we_q;
   assign mem_addr_out = addr_q;
   assign mem_wdata_out = wdata_q;
   assign mem_wstrb_out = wstrb_q;
   assign wb_valid_out = wb_valid_q;
   assign wb_rd_out = wb_rd_q;
   assign wb_data_out = wb_data_q;
endmodule

// File: tb/tb_lsu_exec_unit.sv
// tb_lsu_exec_unit: vector table plus writeback scoreboard for lsu_exec_unit
module tb_lsu_exec_unit;
   logic        clk_in = 1'b0, rst_in = 1'b1;
   logic [3:0]  lsu_uop_in = '0;
   logic [31:0] base_in = '0, imm_in = '0, store_data_in = '0;
   logic [4:0]  rd_in = '0;
   logic        lsu_busy_out, misaligned_out, mem_req_out, mem_we_out;
   logic [31:0] mem_addr_out, mem_wdata_out;
   logic [3:0]  mem_wstrb_out;
   logic        mem_gnt_in = 1'b0, mem_rvalid_in = 1'b0;
   logic [31:0] mem_rdata_in = '0;
   logic        wb_valid_out;
   logic [4:0]  wb_rd_out;
   logic [31:0] wb_data_out;
   int n_chk = 0, n_fail = 0;
   logic [36:0] sb_q[$];

   typedef struct packed {
      logic [3:0]  uop;
      logic [31:0] base, imm, sd;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic [3:0]  gd, rvd;
      logic        mis;
      logic [31:0] addr, wdata;
      logic [3:0]  strb;
      logic [31:0] data;
   } vec_t;
   vec_t v[15];

   lsu_exec_unit dut (
      .clk_in(clk_in), .rst_in(rst_in), .lsu_uop_in(lsu_uop_in), .base_in(base_in),
      .imm_in(imm_in), .store_data_in(store_data_in), .rd_in(rd_in),
      .lsu_busy_out(lsu_busy_out), .misaligned_out(misaligned_out), .mem_req_out(mem_req_out),
      .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
      .mem_wstrb_out(mem_wstrb_out), .mem_gnt_in(mem_gnt_in), .mem_rvalid_in(mem_rvalid_in),
      .mem_rdata_in(mem_rdata_in), .wb_valid_out(wb_valid_out), .wb_rd_out(wb_rd_out),
      .wb_data_out(wb_data_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (!rst_in && wb_valid_out) begin
         logic [36:0] e;
         chk("wb_mis_exclusive", 32'(misaligned_out), 32'd0);
         if (sb_q.size() == 0) chk("wb_unexpected", 32'(wb_valid_out), 32'd0);
         else begin
            e = sb_q.pop_front();
            chk("wb_rd", 32'(wb_rd_out), 32'(e[36:32]));
            chk("wb_data", wb_data_out, e[31:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic run(input vec_t t);
      logic legal, ld;
      legal = t.uop inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
      ld = t.uop < 4'h6;
      step();
      lsu_uop_in = t.uop;
      base_in = t.base;
      imm_in = t.imm;
      store_data_in = t.sd;
      rd_in = t.rd;
      step();
      lsu_uop_in = '0;
      if (!legal) begin
         chk("illegal_busy", 32'(lsu_busy_out), 32'd0);
         chk("illegal_req", 32'(mem_req_out), 32'd0);
         chk("illegal_mis", 32'(misaligned_out), 32'd0);
         return;
      end
      if (t.mis) begin
         chk("mis_pulse", 32'(misaligned_out), 32'd1);
         chk("mis_busy", 32'(lsu_busy_out), 32'd0);
         chk("mis_req", 32'(mem_req_out), 32'd0);
         step();
         chk("mis_pulse_end", 32'(misaligned_out), 32'd0);
         chk("mis_req_after", 32'(mem_req_out), 32'd0);
         return;
      end
      chk("req", 32'(mem_req_out), 32'd1);
      chk("busy", 32'(lsu_busy_out), 32'd1);
      chk("we", 32'(mem_we_out), 32'(!ld));
      chk("addr", mem_addr_out, t.addr);
      chk("wstrb", 32'(mem_wstrb_out), 32'(t.strb));
      if (!ld) chk("wdata", mem_wdata_out, t.wdata);
      for (int i = 0; i < int'(t.gd); i++) begin
         mem_rvalid_in = ld;
         step();
         chk("req_held", 32'(mem_req_out), 32'd1);
         chk("addr_held", mem_addr_out, t.addr);
         chk("wstrb_held", 32'(mem_wstrb_out), 32'(t.strb));
         if (!ld) chk("wdata_held", mem_wdata_out, t.wdata);
      end
      mem_rvalid_in = 1'b0;
      mem_gnt_in = 1'b1;
      step();
      mem_gnt_in = 1'b0;
      chk("req_drop", 32'(mem_req_out), 32'd0);
      if (!ld) begin
         chk("store_done_busy", 32'(lsu_busy_out), 32'd0);
         chk("store_no_wb", 32'(wb_valid_out), 32'd0);
         return;
      end
      chk("wait_busy", 32'(lsu_busy_out), 32'd1);
      if (t.rd != 5'd0) sb_q.push_back({t.rd, t.data});
      for (int i = 0; i < int'(t.rvd); i++) begin
         step();
         chk("rv_wait_busy", 32'(lsu_busy_out), 32'd1);
         chk("rv_wait_wb", 32'(wb_valid_out), 32'd0);
      end
      mem_rvalid_in = 1'b1;
      mem_rdata_in = t.rdata;
      step();
      mem_rvalid_in = 1'b0;
      mem_rdata_in = $urandom;
      chk("wb_valid", 32'(wb_valid_out), 32'(t.rd != 5'd0));
      chk("wb_busy", 32'(lsu_busy_out), 32'd1);
      step();
      chk("post_wb_busy", 32'(lsu_busy_out), 32'd0);
      chk("post_wb_valid", 32'(wb_valid_out), 32'd0);
      if (t.rd != 5'd0) chk("wb_data_hold", wb_data_out, t.data);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"}, 32'(lsu_busy_out), 32'd0);
      chk({nm, "_mis"}, 32'(misaligned_out), 32'd0);
      chk({nm, "_req"}, 32'(mem_req_out), 32'd0);
      chk({nm, "_we"}, 32'(mem_we_out), 32'd0);
      chk({nm, "_addr"}, mem_addr_out, 32'd0);
      chk({nm, "_wdata"}, mem_wdata_out, 32'd0);
      chk({nm, "_wstrb"}, 32'(mem_wstrb_out), 32'd0);
      chk({nm, "_wbv"}, 32'(wb_valid_out), 32'd0);
      chk({nm, "_wbrd"}, 32'(wb_rd_out), 32'd0);
      chk({nm, "_wbdata"}, wb_data_out, 32'd0);
   endtask

   initial begin
      v[0]  = '{4'h3, 32'h1000, 32'h8, 32'h0, 5'd5, 32'hDEADBEEF, 4'd0, 4'd0, 1'b0, 32'h1008, 32'h0, 4'h0, 32'hDEADBEEF};
      v[1]  = '{4'h1, 32'h1000, 32'h3, 32'h0, 5'd7, 32'h80FFFF12, 4'd0, 4'd0, 1'b0, 32'h1000, 32'h0, 4'h0, 32'hFFFFFF80};
      v[2]  = '{4'h4, 32'h1000, 32'h3, 32'h0, 5'd8, 32'h80FFFF12, 4'd0, 4'd0, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h00000080};
      v[3]  = '{4'h2, 32'h1000, 32'h2, 32'h0, 5'd9, 32'h80FFFF12, 4'd1, 4'd0, 1'b0, 32'h1000, 32'h0, 4'h0, 32'hFFFF80FF};
      v[4]  = '{4'h5, 32'h1000, 32'h0, 32'h0, 5'd10, 32'h80FFFF12, 4'd2, 4'd0, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0000FF12};
      v[5]  = '{4'h1, 32'h1000, 32'h1, 32'h0, 5'd11, 32'h12345678, 4'd0, 4'd2, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h00000056};
      v[6]  = '{4'hA, 32'h2000, 32'h4, 32'hCAFEF00D, 5'd1, 32'h0, 4'd0, 4'd0, 1'b0, 32'h2004, 32'hCAFEF00D, 4'hF, 32'h0};
      v[7]  = '{4'h8, 32'h2000, 32'h2, 32'h000000A5, 5'd1, 32'h0, 4'd0, 4'd0, 1'b0, 32'h2000, 32'hA5A5A5A5, 4'h4, 32'h0};
      v[8]  = '{4'h9, 32'h2000, 32'h2, 32'h0000ABCD, 5'd1, 32'h0, 4'd3, 4'd0, 1'b0, 32'h2000, 32'hABCDABCD, 4'hC, 32'h0};
      v[9]  = '{4'h3, 32'h1000, 32'h1, 32'h0, 5'd2, 32'h0, 4'd0, 4'd0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0};
      v[10] = '{4'h9, 32'h0, 32'h3, 32'h1234, 5'd0, 32'h0, 4'd0, 4'd0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0};
      v[11] = '{4'h3, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd3, 32'h11223344, 4'd0, 4'd0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h11223344};
      v[12] = '{4'h3, 32'h40, 32'h0, 32'h0, 5'd0, 32'h55, 4'd0, 4'd0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0};
      v[13] = '{4'h6, 32'h0, 32'h0, 32'h0, 5'd4, 32'h0, 4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
      v[14] = '{4'h8, 32'h3, 32'h0, 32'h12345677, 5'd0, 32'h0, 4'd1, 4'd0, 1'b0, 32'h0, 32'h77777777, 4'h8, 32'h0};
      step();
      step();
      chk_all_zero("reset");
      rst_in = 1'b0;
      for (int i = 0; i < 15; i++) run(v[i]);
      // reset while a load waits for data; the late rvalid must be dropped
      step();
      lsu_uop_in = 4'h3;
      base_in = 32'h500;
      imm_in = 32'h0;
      rd_in = 5'd6;
      step();
      lsu_uop_in = '0;
      mem_gnt_in = 1'b1;
      step();
      mem_gnt_in = 1'b0;
      chk("midrst_wait_busy", 32'(lsu_busy_out), 32'd1);
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      chk_all_zero("midrst");
      mem_rvalid_in = 1'b1;
      mem_rdata_in = 32'hBAD0BAD0;
      step();
      mem_rvalid_in = 1'b0;
      chk("midrst_no_wb", 32'(wb_valid_out), 32'd0);
      chk("midrst_idle", 32'(lsu_busy_out), 32'd0);
      run(v[0]);
      step();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
